// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: FSM state encoding and bus word width.
package mem_ctrl_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/mux16_2to1.sv
// Two-input word multiplexer; D_IN1 is selected when SEL is high.
module mux16_2to1
  import mem_ctrl_pkg::*;
(
  input  logic              SEL,
  input  logic [WORD_W-1:0] D_IN0,
  input  logic [WORD_W-1:0] D_IN1,
  output logic [WORD_W-1:0] D_OUT
);

  assign D_OUT = SEL ? D_IN1 : D_IN0;

endmodule

// File: rtl/mem_ctrl.sv
// MAR/MDR memory interface controller: runs one bus access per MIO_EN request,
// with an ACK handshake to memory and a wait-cycle timeout.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [WORD_W-1:0] BUS_IN,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              MIO_EN,
  input  logic              R_W,
  output logic [WORD_W-1:0] MAR_OUT,
  output logic [WORD_W-1:0] MDR_OUT,
  output logic              R,
  output logic              ERR,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [WORD_W-1:0] MEM_ADDR,
  output logic [WORD_W-1:0] MEM_WDATA,
  input  logic [WORD_W-1:0] MEM_RDATA,
  input  logic              MEM_ACK
);

  localparam logic [7:0] LP_WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t            r_state;
  state_t            w_next;
  logic [WORD_W-1:0] r_mar;
  logic [WORD_W-1:0] r_mdr;
  logic [WORD_W-1:0] w_mdr_d;
  logic [7:0]        r_wait;
  logic              r_we;
  logic              r_err;
  logic              w_in_idle;
  logic              w_in_access;
  logic              w_timeout;
  logic              w_rd_cap;
  logic              w_ld_mdr;

  assign w_in_idle   = (r_state == IDLE);
  assign w_in_access = (r_state == ACCESS);
  // ACK wins over timeout when both land on the last allowed wait cycle.
  assign w_timeout   = w_in_access && !MEM_ACK && (r_wait == LP_WAIT_LAST);
  assign w_rd_cap    = w_in_access && MEM_ACK && !r_we;
  assign w_ld_mdr    = (w_in_idle && LD_MDR) || w_rd_cap;

  mux16_2to1 u_mdr_mux (
    .SEL   (w_rd_cap),
    .D_IN0 (BUS_IN),
    .D_IN1 (MEM_RDATA),
    .D_OUT (w_mdr_d)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (MIO_EN) w_next = ACCESS;
      ACCESS:  if (MEM_ACK || w_timeout) w_next = DONE;
      DONE:    if (!MIO_EN) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_mar   <= '0;
      r_mdr   <= '0;
      r_wait  <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_in_idle && LD_MAR) r_mar <= BUS_IN;
      if (w_ld_mdr) r_mdr <= w_mdr_d;
      if (w_in_idle && MIO_EN) begin
        r_we   <= R_W;
        r_wait <= '0;
        r_err  <= 1'b0;
      end else if (w_in_access) begin
        if (!MEM_ACK && (r_wait != 8'hFF)) r_wait <= r_wait + 8'd1;
        if (w_timeout) r_err <= 1'b1;
      end
    end
  end

  // Memory-side outputs are decoded from state so they vanish outside ACCESS.
  assign MEM_REQ   = w_in_access;
  assign MEM_WE    = w_in_access && r_we;
  assign MEM_ADDR  = w_in_access ? r_mar : '0;
  assign MEM_WDATA = w_in_access ? r_mdr : '0;
  assign R         = (r_state == DONE);
  assign ERR       = r_err;
  assign MAR_OUT   = r_mar;
  assign MDR_OUT   = r_mdr;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl (WAIT_MAX=4): read, write, timeout, ignore, reset, handshake.
module tb_mem_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] BUS_IN;
  logic        LD_MAR, LD_MDR, MIO_EN, R_W;
  logic [15:0] MAR_OUT, MDR_OUT;
  logic        R, ERR, MEM_REQ, MEM_WE;
  logic [15:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
  logic        MEM_ACK;

  int n_chk  = 0;
  int n_pass = 0;

  mem_ctrl #(.WAIT_MAX(4)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .BUS_IN    (BUS_IN),
    .LD_MAR    (LD_MAR),
    .LD_MDR    (LD_MDR),
    .MIO_EN    (MIO_EN),
    .R_W       (R_W),
    .MAR_OUT   (MAR_OUT),
    .MDR_OUT   (MDR_OUT),
    .R         (R),
    .ERR       (ERR),
    .MEM_REQ   (MEM_REQ),
    .MEM_WE    (MEM_WE),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_WDATA (MEM_WDATA),
    .MEM_RDATA (MEM_RDATA),
    .MEM_ACK   (MEM_ACK)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b1; BUS_IN = '0; LD_MAR = 0; LD_MDR = 0; MIO_EN = 0; R_W = 0;
    MEM_RDATA = '0; MEM_ACK = 0;
    step(); step();
    chk("rst_r", 16'(R), 16'd0);
    chk("rst_req", 16'(MEM_REQ), 16'd0);
    chk("rst_we", 16'(MEM_WE), 16'd0);
    chk("rst_addr", MEM_ADDR, 16'h0000);
    chk("rst_wdata", MEM_WDATA, 16'h0000);
    chk("rst_mar", MAR_OUT, 16'h0000);
    chk("rst_mdr", MDR_OUT, 16'h0000);
    chk("rst_err", 16'(ERR), 16'd0);
    RESET = 1'b0;

    // Read with ACK on the 4th ACCESS cycle (last allowed wait).
    BUS_IN = 16'h3000; LD_MAR = 1; step();
    chk("rd_mar", MAR_OUT, 16'h3000);
    chk("rd_idle_req", 16'(MEM_REQ), 16'd0);
    LD_MAR = 0; MIO_EN = 1; R_W = 0; step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rd_req%0d", i), 16'(MEM_REQ), 16'd1);
      chk($sformatf("rd_addr%0d", i), MEM_ADDR, 16'h3000);
      chk($sformatf("rd_we%0d", i), 16'(MEM_WE), 16'd0);
      chk($sformatf("rd_r%0d", i), 16'(R), 16'd0);
      if (i == 3) begin MEM_ACK = 1; MEM_RDATA = 16'hBEEF; end
      step();
    end
    MEM_ACK = 0;
    chk("rd_done_r", 16'(R), 16'd1);
    chk("rd_done_err", 16'(ERR), 16'd0);
    chk("rd_mdr", MDR_OUT, 16'hBEEF);
    chk("rd_done_req", 16'(MEM_REQ), 16'd0);
    MIO_EN = 0; step();
    chk("rd_idle_r", 16'(R), 16'd0);

    // Write, MDR load coincident with MIO_EN, ACK in first ACCESS cycle.
    BUS_IN = 16'h4001; LD_MAR = 1; step();
    LD_MAR = 0; BUS_IN = 16'h1234; LD_MDR = 1; MIO_EN = 1; R_W = 1; step();
    LD_MDR = 0; BUS_IN = 16'h0000;
    chk("wr_req", 16'(MEM_REQ), 16'd1);
    chk("wr_we", 16'(MEM_WE), 16'd1);
    chk("wr_wdata", MEM_WDATA, 16'h1234);
    chk("wr_addr", MEM_ADDR, 16'h4001);
    MEM_ACK = 1; MEM_RDATA = 16'hDEAD; step();
    MEM_ACK = 0;
    chk("wr_done_req", 16'(MEM_REQ), 16'd0);
    chk("wr_done_we", 16'(MEM_WE), 16'd0);
    chk("wr_done_r", 16'(R), 16'd1);
    chk("wr_mdr", MDR_OUT, 16'h1234);
    chk("wr_err", 16'(ERR), 16'd0);
    MIO_EN = 0; step();
    chk("wr_idle_r", 16'(R), 16'd0);

    // Read that times out; loads during ACCESS must be ignored.
    MIO_EN = 1; R_W = 0; step();
    BUS_IN = 16'hFFFF; LD_MDR = 1; LD_MAR = 1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_req%0d", i), 16'(MEM_REQ), 16'd1);
      chk($sformatf("to_addr%0d", i), MEM_ADDR, 16'h4001);
      step();
    end
    LD_MDR = 0; LD_MAR = 0;
    chk("to_r", 16'(R), 16'd1);
    chk("to_err", 16'(ERR), 16'd1);
    chk("to_mdr", MDR_OUT, 16'h1234);
    chk("to_mar", MAR_OUT, 16'h4001);
    chk("to_req_done", 16'(MEM_REQ), 16'd0);

    // Hold MIO_EN past R for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("hs_r%0d", i), 16'(R), 16'd1);
      chk($sformatf("hs_req%0d", i), 16'(MEM_REQ), 16'd0);
    end
    MIO_EN = 0; step();
    chk("hs_idle_r", 16'(R), 16'd0);
    chk("hs_err_hold", 16'(ERR), 16'd1);
    step();
    chk("hs_no_restart", 16'(MEM_REQ), 16'd0);

    // Stray ACK in IDLE.
    MEM_ACK = 1; MEM_RDATA = 16'h5555; step();
    MEM_ACK = 0;
    chk("stray_mdr", MDR_OUT, 16'h1234);
    chk("stray_req", 16'(MEM_REQ), 16'd0);
    chk("stray_r", 16'(R), 16'd0);

    // New access clears ERR; reset lands in the 2nd ACCESS cycle.
    MIO_EN = 1; R_W = 1; step();
    chk("re_err_clr", 16'(ERR), 16'd0);
    chk("re_req", 16'(MEM_REQ), 16'd1);
    step();
    chk("re_req2", 16'(MEM_REQ), 16'd1);
    RESET = 1; step();
    chk("mrst_req", 16'(MEM_REQ), 16'd0);
    chk("mrst_mar", MAR_OUT, 16'h0000);
    chk("mrst_mdr", MDR_OUT, 16'h0000);
    RESET = 0; MIO_EN = 0; MEM_ACK = 1; MEM_RDATA = 16'h7777; step();
    MEM_ACK = 0;
    chk("late_ack_mdr", MDR_OUT, 16'h0000);
    chk("late_ack_r", 16'(R), 16'd0);
    chk("late_ack_req", 16'(MEM_REQ), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
